elevator_controller: RTL and testbench
======================================

ELEVATOR_CONTROLLER -- requirements
Module: elevator_controller

Interface
REQ-001 SHALL have parameter TRAVEL_CYCLES, default 4, clock cycles to travel one floor (legal range 1..255).
REQ-002 SHALL have parameter DOOR_CYCLES, default 3, clock cycles the door stays open (legal range 1..255).
REQ-003 SHALL have port clk  input  1  the only clock; all registers update on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset; low forces the reset state immediately, regardless of clk.
REQ-005 SHALL have port hall_req  input  4  outer-button call pulses, bit n = floor n.
REQ-006 SHALL have port car_req  input  4  inner-button call pulses, bit n = floor n.
REQ-007 SHALL have port floor  output  2  current car floor (0..3), registered.
REQ-008 SHALL have port state  output  2  FSM state: 00 IDLE, 01 MOVE_UP, 10 MOVE_DOWN, 11 DOOR.
REQ-009 SHALL have port door_open  output  1  high exactly while state = DOOR.
REQ-010 SHALL have port pending  output  4  latched, unserved requests.
REQ-011 SHALL have port arrive  output  1  one-cycle pulse on each floor change.

Function
REQ-012 SHALL sample the request vector req = hall_req | car_req on every edge; each req bit SHALL set its pending bit, except as stated in REQ-019.
REQ-013 SHALL keep each pending bit set until that floor is served; a bit SHALL clear only on entry to DOOR at that floor.
REQ-014 SHALL, in IDLE, use the registered pending value and decide in this priority order:
  - pending[floor] set -> DOOR.
  - Otherwise, pending above floor and (last direction up, or nothing pending below) -> MOVE_UP.
  - Otherwise, pending below floor -> MOVE_DOWN.
  - Otherwise -> stay in IDLE.
REQ-015 SHALL load the travel timer with TRAVEL_CYCLES on entry to MOVE_UP or MOVE_DOWN and decrement it by one each cycle.
REQ-016 SHALL, on the edge where the travel timer reaches expiry:
  - change floor by +1 (MOVE_UP) or -1 (MOVE_DOWN) and pulse arrive.
  - In the same edge: pending[new floor] set -> DOOR; else pending further in the same direction -> stay in MOVE and reload the timer; else -> IDLE.
REQ-017 SHALL record the last direction (reset value: up) on every MOVE entry.
REQ-018 SHALL, on DOOR entry, clear pending[floor], assert door_open and load the door timer with DOOR_CYCLES; when the door timer expires the FSM SHALL go to IDLE.
REQ-019 SHALL treat a request for the current floor during DOOR as follows: the pending bit is not set and the door timer reloads with DOOR_CYCLES.
REQ-020 SHALL latch a request for the just-departed floor during MOVE as a normal pending request.
REQ-021 SHALL never move above floor 3 or below floor 0; MOVE_UP is unreachable at floor 3 and MOVE_DOWN at floor 0 by construction.
REQ-022 SHALL, when a pending bit is set on the same edge as DOOR entry at that floor, leave the bit cleared.
REQ-023 SHALL use 8-bit timers; floor SHALL never wrap.

Reset
REQ-024 SHALL, with reset low, drive: floor=0, state=IDLE, pending=0, door_open=0, arrive=0, timers=0, last direction=up.
REQ-025 SHALL discard all pending requests and return to floor 0 when reset is asserted mid-MOVE or mid-DOOR.
REQ-026 SHALL resume normal operation on the first rising clk edge after reset deasserts.

Verification (defaults TRAVEL_CYCLES=4, DOOR_CYCLES=3; E0 = edge sampling the pulse)
REQ-027 SHALL cover a single trip:
  - Stimulus: car_req=0100 at E0, idle at floor 0.
  - Response: MOVE_UP at E1; floor=1 with arrive at E5; floor=2, DOOR and pending=0 at E9; IDLE at E12.
REQ-028 SHALL cover a current-floor call: hall_req=0001 at floor 0, IDLE -> DOOR at E1; door_open high for 3 cycles; no movement.
REQ-029 SHALL cover direction preference:
  - Stimulus: at floor 1, last direction up, pending=1001.
  - Response: serve floor 3 first (MOVE_UP), then floor 0.
REQ-030 SHALL cover door extension: car_req for the current floor at the second DOOR cycle -> door timer reloads; door_open stays high for 3 further cycles; pending stays 0.
REQ-031 SHALL cover an en-route stop:
  - Stimulus: moving up from floor 0 toward floor 3; hall_req=0010 before the floor-1 arrival.
  - Response: DOOR at floor 1, then resume MOVE_UP to floor 3.
REQ-032 SHALL cover reset mid-MOVE: reset low asynchronously -> floor=0, state=00 and pending=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/elevator_controller_if.sv
// Request/status bundle between the elevator controller and its environment.
interface elevator_controller_if;
    logic [3:0] hall_req;
    logic [3:0] car_req;
    logic [1:0] floor;
    logic [1:0] state;
    logic       door_open;
    logic [3:0] pending;
    logic       arrive;

    // Environment side: raises calls, observes car status.
    modport master (
        output hall_req, car_req,
        input  floor, state, door_open, pending, arrive
    );

    // Controller side.
    modport slave (
        input  hall_req, car_req,
        output floor, state, door_open, pending, arrive
    );
endinterface

// File: rtl/elevator_controller.sv
// Four-floor elevator controller: latches calls, moves one floor per
// TRAVEL_CYCLES, holds the door for DOOR_CYCLES and prefers to keep going
// in the last direction of travel.
module elevator_controller #(
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    elevator_controller_if.slave  bus
);

    localparam int unsigned NF = 4;
    localparam int unsigned FW = 2;
    localparam int unsigned TW = 8;

    localparam logic [TW-1:0] TRAVEL_LD = TW'(TRAVEL_CYCLES);
    localparam logic [TW-1:0] DOOR_LD   = TW'(DOOR_CYCLES);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        MOVE_UP   = 2'b01,
        MOVE_DOWN = 2'b10,
        DOOR      = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic [FW-1:0]   floor_q, floor_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [NF-1:0]   pending_q, pending_d;
    logic            dir_up_q, dir_up_d;
    logic            arrive_q, arrive_d;
    logic            door_open_q, door_open_d;

    logic [NF-1:0]   req;
    logic [FW-1:0]   step_floor;
    logic            expire;

    // Floors strictly above / below floor f.
    function automatic logic [NF-1:0] above_mask(input logic [FW-1:0] f);
        above_mask = NF'(4'b1110 << f);
    endfunction

    function automatic logic [NF-1:0] below_mask(input logic [FW-1:0] f);
        below_mask = NF'((4'b0001 << f) - 4'd1);
    endfunction

    assign req    = bus.hall_req | bus.car_req;
    assign expire = (timer_q <= TW'(1));

    // Next-state, timer and request bookkeeping.
    always_comb begin
        state_d     = state_q;
        floor_d     = floor_q;
        timer_d     = timer_q;
        dir_up_d    = dir_up_q;
        arrive_d    = 1'b0;
        pending_d   = pending_q | req;
        step_floor  = floor_q;

        case (state_q)
            IDLE: begin
                if (pending_q[floor_q]) begin
                    state_d            = DOOR;
                    timer_d            = DOOR_LD;
                    pending_d[floor_q] = 1'b0;
                end else if ((|(pending_q & above_mask(floor_q))) &&
                             (dir_up_q || !(|(pending_q & below_mask(floor_q))))) begin
                    state_d  = MOVE_UP;
                    timer_d  = TRAVEL_LD;
                    dir_up_d = 1'b1;
                end else if (|(pending_q & below_mask(floor_q))) begin
                    state_d  = MOVE_DOWN;
                    timer_d  = TRAVEL_LD;
                    dir_up_d = 1'b0;
                end
            end

            MOVE_UP, MOVE_DOWN: begin
                if (expire) begin
                    step_floor = (state_q == MOVE_UP) ? floor_q + FW'(1) : floor_q - FW'(1);
                    floor_d    = step_floor;
                    arrive_d   = 1'b1;
                    if (pending_q[step_floor]) begin
                        state_d               = DOOR;
                        timer_d               = DOOR_LD;
                        pending_d[step_floor] = 1'b0;
                    end else if ((state_q == MOVE_UP) ?
                                 (|(pending_q & above_mask(step_floor))) :
                                 (|(pending_q & below_mask(step_floor)))) begin
                        timer_d = TRAVEL_LD;
                    end else begin
                        state_d = IDLE;
                        timer_d = '0;
                    end
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            DOOR: begin
                // A call for the floor we are standing at just holds the door.
                if (req[floor_q]) begin
                    timer_d            = DOOR_LD;
                    pending_d[floor_q] = 1'b0;
                end else if (expire) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        door_open_d = (state_d == DOOR);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            floor_q     <= '0;
            timer_q     <= '0;
            pending_q   <= '0;
            dir_up_q    <= 1'b1;
            arrive_q    <= 1'b0;
            door_open_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            floor_q     <= floor_d;
            timer_q     <= timer_d;
            pending_q   <= pending_d;
            dir_up_q    <= dir_up_d;
            arrive_q    <= arrive_d;
            door_open_q <= door_open_d;
        end
    end

    assign bus.floor     = floor_q;
    assign bus.state     = 2'(state_q);
    assign bus.door_open = door_open_q;
    assign bus.pending   = pending_q;
    assign bus.arrive    = arrive_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Scoreboard bench for elevator_controller: each scenario pushes the
// expected car status for given edges after its first call, and a negedge
// monitor pops and compares them as those edges go by.
module tb_elevator_controller;

    localparam logic [1:0] S_I = 2'b00;
    localparam logic [1:0] S_U = 2'b01;
    localparam logic [1:0] S_D = 2'b10;
    localparam logic [1:0] S_R = 2'b11;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  fl;
        logic [1:0]  st;
        logic [3:0]  pend;
        logic        dopen;
        logic        arr;
        string       tag;
    } exp_t;

    logic        clk;
    logic        reset;
    int unsigned cyc;
    int unsigned base;
    string       tname;
    int          checks;
    int          errors;
    exp_t        sb_q[$];
    exp_t        mon_e;

    elevator_controller_if ifc();

    elevator_controller #(
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge index since reset release; value k at a negedge means "after Ek".
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic exp_at(input int unsigned off, input logic [1:0] fl, input logic [1:0] st,
                          input logic [3:0] pend, input logic dopen, input logic arr);
        exp_t e;
        e.cyc   = base + off;
        e.fl    = fl;
        e.st    = st;
        e.pend  = pend;
        e.dopen = dopen;
        e.arr   = arr;
        e.tag   = $sformatf("%s@E%0d", tname, off);
        sb_q.push_back(e);
    endtask

    // Drive a one-cycle call pulse so that edge k samples it (call at a negedge).
    task automatic drive_at(input int unsigned k, input logic [3:0] h, input logic [3:0] c);
        while (cyc + 1 < k) @(negedge clk);
        ifc.hall_req = h;
        ifc.car_req  = c;
        @(negedge clk);
        ifc.hall_req = '0;
        ifc.car_req  = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "/floor"},   8'(ifc.floor),     8'h0);
        check_val({tag, "/state"},   8'(ifc.state),     8'h0);
        check_val({tag, "/pending"}, 8'(ifc.pending),   8'h0);
        check_val({tag, "/door"},    8'(ifc.door_open), 8'h0);
        check_val({tag, "/arrive"},  8'(ifc.arrive),    8'h0);
    endtask

    // Scoreboard monitor: compare every expectation due at this edge.
    always @(negedge clk) begin
        while (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
            mon_e = sb_q.pop_front();
            check_val($sformatf("%s/floor", mon_e.tag),   8'(ifc.floor),     8'(mon_e.fl));
            check_val($sformatf("%s/state", mon_e.tag),   8'(ifc.state),     8'(mon_e.st));
            check_val($sformatf("%s/pending", mon_e.tag), 8'(ifc.pending),   8'(mon_e.pend));
            check_val($sformatf("%s/door", mon_e.tag),    8'(ifc.door_open), 8'(mon_e.dopen));
            check_val($sformatf("%s/arrive", mon_e.tag),  8'(ifc.arrive),    8'(mon_e.arr));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        ifc.hall_req = '0;
        ifc.car_req  = '0;
        repeat (3) @(negedge clk);
        check_reset_state("por");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Call for the floor the car is idling at.
        tname = "cur_floor";
        base  = cyc + 1;
        exp_at(0, 2'd0, S_I, 4'b0001, 1'b0, 1'b0);
        exp_at(1, 2'd0, S_R, 4'b0000, 1'b1, 1'b0);
        exp_at(2, 2'd0, S_R, 4'b0000, 1'b1, 1'b0);
        exp_at(3, 2'd0, S_R, 4'b0000, 1'b1, 1'b0);
        exp_at(4, 2'd0, S_I, 4'b0000, 1'b0, 1'b0);
        exp_at(5, 2'd0, S_I, 4'b0000, 1'b0, 1'b0);
        drive_at(base, 4'b0001, 4'b0000);
        drain();

        // Single trip 0 -> 2.
        tname = "single_trip";
        base  = cyc + 1;
        exp_at(0,  2'd0, S_I, 4'b0100, 1'b0, 1'b0);
        exp_at(1,  2'd0, S_U, 4'b0100, 1'b0, 1'b0);
        exp_at(4,  2'd0, S_U, 4'b0100, 1'b0, 1'b0);
        exp_at(5,  2'd1, S_U, 4'b0100, 1'b0, 1'b1);
        exp_at(6,  2'd1, S_U, 4'b0100, 1'b0, 1'b0);
        exp_at(9,  2'd2, S_R, 4'b0000, 1'b1, 1'b1);
        exp_at(10, 2'd2, S_R, 4'b0000, 1'b1, 1'b0);
        exp_at(11, 2'd2, S_R, 4'b0000, 1'b1, 1'b0);
        exp_at(12, 2'd2, S_I, 4'b0000, 1'b0, 1'b0);
        drive_at(base, 4'b0000, 4'b0100);
        drain();

        // Door held by a same-floor call during the door phase.
        tname = "door_ext";
        base  = cyc + 1;
        exp_at(0, 2'd2, S_I, 4'b0100, 1'b0, 1'b0);
        exp_at(1, 2'd2, S_R, 4'b0000, 1'b1, 1'b0);
        exp_at(2, 2'd2, S_R, 4'b0000, 1'b1, 1'b0);
        exp_at(3, 2'd2, S_R, 4'b0000, 1'b1, 1'b0);
        exp_at(4, 2'd2, S_R, 4'b0000, 1'b1, 1'b0);
        exp_at(5, 2'd2, S_I, 4'b0000, 1'b0, 1'b0);
        drive_at(base,     4'b0100, 4'b0000);
        drive_at(base + 2, 4'b0000, 4'b0100);
        drain();

        // Asynchronous reset while travelling down.
        tname = "mid_reset";
        base  = cyc + 1;
        exp_at(0, 2'd2, S_I, 4'b0001, 1'b0, 1'b0);
        exp_at(1, 2'd2, S_D, 4'b0001, 1'b0, 1'b0);
        exp_at(5, 2'd1, S_D, 4'b0001, 1'b0, 1'b1);
        exp_at(6, 2'd1, S_D, 4'b0001, 1'b0, 1'b0);
        drive_at(base, 4'b0000, 4'b0001);
        while (cyc < base + 6) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_reset_state("mid_reset_async");
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Direction preference from floor 1 with calls above and below.
        tname = "dir_pref";
        base  = cyc + 1;
        exp_at(0,  2'd0, S_I, 4'b0010, 1'b0, 1'b0);
        exp_at(1,  2'd0, S_U, 4'b0010, 1'b0, 1'b0);
        exp_at(5,  2'd1, S_R, 4'b0000, 1'b1, 1'b1);
        exp_at(6,  2'd1, S_R, 4'b1001, 1'b1, 1'b0);
        exp_at(7,  2'd1, S_R, 4'b1001, 1'b1, 1'b0);
        exp_at(8,  2'd1, S_I, 4'b1001, 1'b0, 1'b0);
        exp_at(9,  2'd1, S_U, 4'b1001, 1'b0, 1'b0);
        exp_at(13, 2'd2, S_U, 4'b1001, 1'b0, 1'b1);
        exp_at(17, 2'd3, S_R, 4'b0001, 1'b1, 1'b1);
        exp_at(20, 2'd3, S_I, 4'b0001, 1'b0, 1'b0);
        exp_at(21, 2'd3, S_D, 4'b0001, 1'b0, 1'b0);
        exp_at(25, 2'd2, S_D, 4'b0001, 1'b0, 1'b1);
        exp_at(29, 2'd1, S_D, 4'b0001, 1'b0, 1'b1);
        exp_at(33, 2'd0, S_R, 4'b0000, 1'b1, 1'b1);
        exp_at(36, 2'd0, S_I, 4'b0000, 1'b0, 1'b0);
        drive_at(base,     4'b0000, 4'b0010);
        drive_at(base + 6, 4'b0000, 4'b1001);
        drain();

        // En-route stop at floor 1 on the way to floor 3.
        tname = "en_route";
        base  = cyc + 1;
        exp_at(0,  2'd0, S_I, 4'b1000, 1'b0, 1'b0);
        exp_at(1,  2'd0, S_U, 4'b1000, 1'b0, 1'b0);
        exp_at(3,  2'd0, S_U, 4'b1010, 1'b0, 1'b0);
        exp_at(5,  2'd1, S_R, 4'b1000, 1'b1, 1'b1);
        exp_at(8,  2'd1, S_I, 4'b1000, 1'b0, 1'b0);
        exp_at(9,  2'd1, S_U, 4'b1000, 1'b0, 1'b0);
        exp_at(13, 2'd2, S_U, 4'b1000, 1'b0, 1'b1);
        exp_at(17, 2'd3, S_R, 4'b0000, 1'b1, 1'b1);
        exp_at(20, 2'd3, S_I, 4'b0000, 1'b0, 1'b0);
        drive_at(base,     4'b0000, 4'b1000);
        drive_at(base + 3, 4'b0010, 4'b0000);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
